// File: rtl/pipelined_prefix_adder_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Kogge-Stone adder.
// Prefix depth, register-stage count and latency are all derived here.
package prefix_adder_pkg;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } op_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int calc_log2w(input int width);
    return clog2(width);
  endfunction

  // Prefix levels are grouped LPS at a time; a partial last group still costs a register.
  function automatic int calc_ng(input int width, input int lps);
    return (calc_log2w(width) + lps - 1) / lps;
  endfunction

  function automatic int calc_lat(input int width, input int lps);
    return calc_ng(width, lps) + 2;
  endfunction

endpackage

// File: rtl/pipelined_prefix_adder_if.sv
// Operand/result stream bundle for the prefix adder.
// The master drives operands and out_ready; the slave (adder) returns the result beat.
interface pipelined_prefix_adder_if #(
  parameter int WIDTH = 25,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, a, b, cin, sub, in_tag, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, out_tag
  );

  modport slave (
    input  in_valid, a, b, cin, sub, in_tag, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, out_tag
  );
endinterface

// File: rtl/pipelined_prefix_adder_prefix_level.sv
// One Kogge-Stone prefix level: combines each (P,G) pair with the pair DIST bits below.
// Bits below DIST have no partner and pass straight through.
module prefix_level #(
  parameter int WIDTH = 25,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0] g_i,
  output logic [WIDTH-1:0] p_o,
  output logic [WIDTH-1:0] g_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i < DIST) begin : g_pass
      assign p_o[i] = p_i[i];
      assign g_o[i] = g_i[i];
    end else begin : g_comb
      assign g_o[i] = g_i[i] | (p_i[i] & g_i[i-DIST]);
      assign p_o[i] = p_i[i] & p_i[i-DIST];
    end
  end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with a lock-step valid/ready pipeline.
// Input register, NG prefix-group registers, then a registered sum/flag stage.
module pipelined_prefix_adder
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH            = 25,
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_W            = 4
) (
  input logic                    clk,
  input logic                    rst,
  pipelined_prefix_adder_if.slave bus
);

  localparam int LOG2W = calc_log2w(WIDTH);
  localparam int NG    = calc_ng(WIDTH, LEVELS_PER_STAGE);

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic [NG:0]      v_q;
  logic [NG:0]      cin_q;
  logic [WIDTH-1:0] p_q   [0:NG];
  logic [WIDTH-1:0] pr_q  [0:NG];
  logic [WIDTH-1:0] gr_q  [0:NG];
  logic [TAG_W-1:0] tag_q [0:NG];
  logic [WIDTH-1:0] grp_p [1:NG];
  logic [WIDTH-1:0] grp_g [1:NG];

  logic [WIDTH-1:0] carry_d, sum_d;
  logic             cout_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, zero_q, out_valid_q;
  logic [TAG_W-1:0] out_tag_q;

  assign stall        = out_valid_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign b_eff        = (op_e'(bus.sub) == SUB) ? ~bus.b : bus.b;

  // Level k reads a register when it opens a group, otherwise the previous level.
  for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
    logic [WIDTH-1:0] p_in, g_in, p_out, g_out;
    if (k % LEVELS_PER_STAGE == 0) begin : g_from_reg
      assign p_in = pr_q[k / LEVELS_PER_STAGE];
      assign g_in = gr_q[k / LEVELS_PER_STAGE];
    end else begin : g_from_lvl
      assign p_in = g_lvl[k-1].p_out;
      assign g_in = g_lvl[k-1].g_out;
    end
    prefix_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_level (
      .p_i(p_in),
      .g_i(g_in),
      .p_o(p_out),
      .g_o(g_out)
    );
  end

  for (genvar j = 1; j <= NG; j++) begin : g_grp
    localparam int LAST = ((j * LEVELS_PER_STAGE < LOG2W) ? j * LEVELS_PER_STAGE : LOG2W) - 1;
    assign grp_p[j] = g_lvl[LAST].p_out;
    assign grp_g[j] = g_lvl[LAST].g_out;
  end

  // Full-width group terms let cin enter every carry in one step.
  assign carry_d = {gr_q[NG][WIDTH-2:0] | (pr_q[NG][WIDTH-2:0] & {(WIDTH-1){cin_q[NG]}}),
                    cin_q[NG]};
  assign sum_d   = p_q[NG] ^ carry_d;
  assign cout_d  = gr_q[NG][WIDTH-1] | (pr_q[NG][WIDTH-1] & cin_q[NG]);

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      cin_q <= '0;
      for (int j = 0; j <= NG; j++) begin
        p_q[j]   <= '0;
        pr_q[j]  <= '0;
        gr_q[j]  <= '0;
        tag_q[j] <= '0;
      end
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_tag_q   <= '0;
    end else if (!stall) begin
      v_q      <= {v_q[NG-1:0], bus.in_valid};
      cin_q    <= {cin_q[NG-1:0], bus.cin};
      p_q[0]   <= bus.a ^ b_eff;
      pr_q[0]  <= bus.a ^ b_eff;
      gr_q[0]  <= bus.a & b_eff;
      tag_q[0] <= bus.in_tag;
      for (int j = 1; j <= NG; j++) begin
        p_q[j]   <= p_q[j-1];
        pr_q[j]  <= grp_p[j];
        gr_q[j]  <= grp_g[j];
        tag_q[j] <= tag_q[j-1];
      end
      out_valid_q <= v_q[NG];
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= carry_d[WIDTH-1] ^ cout_d;
      zero_q      <= ~|sum_d;
      out_tag_q   <= tag_q[NG];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.out_tag   = out_tag_q;

endmodule
